// File: rtl/bitserial_alu_issue_if.sv
// Handshake bundle for the bit-serial ALU issue stage: decode request, writeback
// response and the start/done link to the ALU. "master" is the issue-stage side.
interface bitserial_alu_issue_if #(
    parameter int unsigned TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic             req_funct7b5;
    logic             req_is_imm;
    logic [TAG_W-1:0] req_rd;
    logic [31:0]      req_a;
    logic [31:0]      req_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [TAG_W-1:0] rsp_rd;
    logic [31:0]      rsp_result;
    logic             rsp_err;

    logic             alu_start;
    logic [3:0]       alu_op;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_result;
    logic             alu_done;

    logic             busy;

    modport master (
        input  req_valid, req_funct3, req_funct7b5, req_is_imm, req_rd, req_a, req_b,
        output req_ready,
        output rsp_valid, rsp_rd, rsp_result, rsp_err,
        input  rsp_ready,
        output alu_start, alu_op, alu_a, alu_b,
        input  alu_result, alu_done,
        output busy
    );

    modport slave (
        output req_valid, req_funct3, req_funct7b5, req_is_imm, req_rd, req_a, req_b,
        input  req_ready,
        input  rsp_valid, rsp_rd, rsp_result, rsp_err,
        output rsp_ready,
        input  alu_start, alu_op, alu_a, alu_b,
        output alu_result, alu_done,
        input  busy
    );
endinterface

// File: rtl/bitserial_alu_issue.sv
// Issue stage in front of a bit-serial ALU: one RV32I op at a time, SLT/SLTU derived from SUB.
// Optional macro ALU_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT_CYCLES) that flags rsp_err.
//
// state  | meaning
// IDLE   | ready for a request
// ISSUE  | operands/op latched, alu_start pulsed
// WAIT   | waiting for alu_done (or watchdog expiry)
// RESP   | response held until rsp_ready
module bitserial_alu_issue #(
    parameter int unsigned TAG_W = 5
`ifdef ALU_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                    clk,
    input  logic                    rstn,
    bitserial_alu_issue_if.master   bus
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
    typedef enum logic [1:0] {PP_NONE, PP_SLT, PP_SLTU} pp_t;

    state_t           state_q, state_d;
    pp_t              pp_q, dec_pp;
    logic [3:0]       op_q, dec_op;
    logic [TAG_W-1:0] rd_q;
    logic [31:0]      a_q, b_q, result_q;
    logic             slt_bit;
    logic             timeout;

    always_comb begin
        dec_op = OP_ADD;
        dec_pp = PP_NONE;
        case (bus.req_funct3)
            3'b000: dec_op = (bus.req_funct7b5 && !bus.req_is_imm) ? OP_SUB : OP_ADD;
            3'b001: dec_op = OP_SLL;
            3'b010: begin dec_op = OP_SUB; dec_pp = PP_SLT;  end
            3'b011: begin dec_op = OP_SUB; dec_pp = PP_SLTU; end
            3'b100: dec_op = OP_XOR;
            3'b101: dec_op = bus.req_funct7b5 ? OP_SRA : OP_SRL;
            3'b110: dec_op = OP_OR;
            default: dec_op = OP_AND;
        endcase
    end

    // On differing signs the SUB result can overflow, so the operand sign decides.
    assign slt_bit = (a_q[31] != b_q[31]) ? ((pp_q == PP_SLT) ? a_q[31] : b_q[31])
                                          : bus.alu_result[31];

`ifdef ALU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                end
                ST_WAIT: begin
                    if (bus.alu_done) err_q <= 1'b0;
                    else if (timeout) err_q <= 1'b1;
                    else              cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign timeout     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.req_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (bus.alu_done || timeout) state_d = ST_RESP;
            default:  if (bus.rsp_ready) state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.busy      = (state_q != ST_IDLE);
        bus.alu_start = (state_q == ST_ISSUE);
        bus.rsp_valid = (state_q == ST_RESP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q     <= '0;
            op_q     <= OP_ADD;
            pp_q     <= PP_NONE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        rd_q <= bus.req_rd;
                        op_q <= dec_op;
                        pp_q <= dec_pp;
                        a_q  <= bus.req_a;
                        b_q  <= bus.req_b;
                    end
                end
                ST_WAIT: begin
                    if (bus.alu_done)
                        result_q <= (pp_q == PP_NONE) ? bus.alu_result : {31'b0, slt_bit};
                    else if (timeout)
                        result_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_rd     = rd_q;
    assign bus.rsp_result = result_q;
    assign bus.alu_op     = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
endmodule

// File: tb/tb_bitserial_alu_issue.sv
// Directed bench for bitserial_alu_issue with a behavioural bit-serial ALU
// (done 1+32 edges after start, or 1+shamt edges for shifts).
module tb_bitserial_alu_issue;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rstn;
    int   errors = 0;
    int   checks = 0;
    int   edges;

    always #5 clk = ~clk;

    bitserial_alu_issue_if #(.TAG_W(TAG_W)) bus ();

    bitserial_alu_issue #(.TAG_W(TAG_W)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.master)
    );

    logic        m_done, m_run, extra_done;
    logic [31:0] m_res, m_a, m_b;
    logic [3:0]  m_op;
    int          m_rem;

    assign bus.alu_done   = m_done | extra_done;
    assign bus.alu_result = m_res;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            default: return $unsigned($signed(a) >>> b[4:0]);
        endcase
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_done <= 1'b0; m_run <= 1'b0; m_rem <= 0;
            m_res <= '0; m_a <= '0; m_b <= '0; m_op <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_run) begin
                if (m_rem == 0) begin
                    m_done <= 1'b1;
                    m_res  <= alu_f(m_op, m_a, m_b);
                    m_run  <= 1'b0;
                end else begin
                    m_rem <= m_rem - 1;
                end
            end else if (bus.alu_start) begin
                m_run <= 1'b1;
                m_op  <= bus.alu_op;
                m_a   <= bus.alu_a;
                m_b   <= bus.alu_b;
                m_rem <= (bus.alu_op >= 4'd5) ? int'(bus.alu_b[4:0]) : 32;
            end
        end
    end

`ifdef ALU_TIMEOUT_EN
    // Second instance with a short watchdog and an ALU that never answers on its own.
    bitserial_alu_issue_if #(.TAG_W(TAG_W)) bus_t ();
    logic late_done;
    assign bus_t.alu_done   = late_done;
    assign bus_t.alu_result = 32'h0000_0000;

    bitserial_alu_issue #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(16)) dut_t (
        .clk (clk),
        .rstn(rstn),
        .bus (bus_t.master)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Accept on the next edge (edge 0) and run until rsp_valid; checks latency.
    task automatic issue(input string tag, input logic [2:0] f3, input logic f7, input logic imm,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat);
        bus.req_funct3   = f3;
        bus.req_funct7b5 = f7;
        bus.req_is_imm   = imm;
        bus.req_rd       = rd;
        bus.req_a        = a;
        bus.req_b        = b;
        bus.req_valid    = 1'b1;
        chk({tag, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        edges = 0;
        chk({tag, " alu_start"}, 32'(bus.alu_start), 32'd1);
        chk({tag, " req_ready busy"}, 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        edges = 1;
        chk({tag, " alu_start drop"}, 32'(bus.alu_start), 32'd0);
        while (!bus.rsp_valid && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, " latency"}, 32'(edges), 32'(exp_lat));
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] res, input logic [4:0] rd);
        chk({tag, " result"}, bus.rsp_result, res);
        chk({tag, " rd"}, 32'(bus.rsp_rd), 32'(rd));
        chk({tag, " err"}, 32'(bus.rsp_err), 32'd0);
    endtask

    task automatic release_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk({tag, " rsp_valid drop"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, " req_ready back"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rstn = 1'b0;
        extra_done = 1'b0;
        bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_funct7b5 = 1'b0;
        bus.req_is_imm = 1'b0; bus.req_rd = '0; bus.req_a = '0; bus.req_b = '0;
        bus.rsp_ready = 1'b0;
`ifdef ALU_TIMEOUT_EN
        late_done = 1'b0;
        bus_t.req_valid = 1'b0; bus_t.req_funct3 = '0; bus_t.req_funct7b5 = 1'b0;
        bus_t.req_is_imm = 1'b0; bus_t.req_rd = '0; bus_t.req_a = '0; bus_t.req_b = '0;
        bus_t.rsp_ready = 1'b0;
`endif
        #2;
        chk("reset req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset alu_start", 32'(bus.alu_start), 32'd0);
        chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("reset rsp_rd", 32'(bus.rsp_rd), 32'd0);
        chk("reset rsp_result", bus.rsp_result, 32'd0);
        chk("reset alu_op", 32'(bus.alu_op), 32'd0);
        chk("reset alu_a", bus.alu_a, 32'd0);
        chk("reset alu_b", bus.alu_b, 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        issue("add", 3'b000, 1'b0, 1'b0, 5'd3, 32'd5, 32'd7, 35);
        chk("add alu_op", 32'(bus.alu_op), 32'd0);
        chk("add alu_a", bus.alu_a, 32'd5);
        chk("add alu_b", bus.alu_b, 32'd7);
        check_rsp("add", 32'd12, 5'd3);
        release_rsp("add");

        issue("sub", 3'b000, 1'b1, 1'b0, 5'd1, 32'd3, 32'd5, 35);
        chk("sub alu_op", 32'(bus.alu_op), 32'd1);
        check_rsp("sub", 32'hFFFF_FFFE, 5'd1);
        release_rsp("sub");

        issue("addi f7b5", 3'b000, 1'b1, 1'b1, 5'd2, 32'd3, 32'd5, 35);
        check_rsp("addi f7b5", 32'd8, 5'd2);
        release_rsp("addi f7b5");

        issue("slt neg", 3'b010, 1'b0, 1'b0, 5'd4, 32'hFFFF_FFFF, 32'd1, 35);
        check_rsp("slt neg", 32'd1, 5'd4);
        release_rsp("slt neg");

        issue("sltu", 3'b011, 1'b0, 1'b0, 5'd5, 32'hFFFF_FFFF, 32'd1, 35);
        check_rsp("sltu", 32'd0, 5'd5);
        release_rsp("sltu");

        issue("slt ovf", 3'b010, 1'b0, 1'b0, 5'd6, 32'h8000_0000, 32'h7FFF_FFFF, 35);
        check_rsp("slt ovf", 32'd1, 5'd6);
        release_rsp("slt ovf");

        issue("slt same sign", 3'b010, 1'b0, 1'b0, 5'd7, 32'd9, 32'd4, 35);
        check_rsp("slt same sign", 32'd0, 5'd7);
        release_rsp("slt same sign");

        issue("sra", 3'b101, 1'b1, 1'b0, 5'd8, 32'h8000_0000, 32'd4, 7);
        chk("sra alu_op", 32'(bus.alu_op), 32'd7);
        check_rsp("sra", 32'hF800_0000, 5'd8);
        release_rsp("sra");

        issue("srl shamt5", 3'b101, 1'b0, 1'b0, 5'd9, 32'h8000_0000, 32'h0000_0024, 7);
        check_rsp("srl shamt5", 32'h0800_0000, 5'd9);
        release_rsp("srl shamt5");

        issue("sll0", 3'b001, 1'b0, 1'b0, 5'd10, 32'h1234_5678, 32'd0, 3);
        check_rsp("sll0", 32'h1234_5678, 5'd10);
        release_rsp("sll0");

        issue("xor", 3'b100, 1'b0, 1'b0, 5'd11, 32'h0000_F0F0, 32'h0000_FF00, 35);
        check_rsp("xor", 32'h0000_0FF0, 5'd11);
        release_rsp("xor");

        issue("or", 3'b110, 1'b0, 1'b0, 5'd12, 32'h0000_F0F0, 32'h0000_FF00, 35);
        check_rsp("or", 32'h0000_FFF0, 5'd12);
        release_rsp("or");

        issue("and", 3'b111, 1'b0, 1'b1, 5'd13, 32'h0000_F0F0, 32'h0000_FF00, 35);
        check_rsp("and", 32'h0000_F000, 5'd13);
        release_rsp("and");

        // Stray done while idle must not start a response.
        extra_done = 1'b1;
        @(posedge clk); #1;
        extra_done = 1'b0;
        chk("idle done rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("idle done busy", 32'(bus.busy), 32'd0);

        // Backpressure: response held, second request refused.
        issue("stall", 3'b000, 1'b0, 1'b0, 5'd9, 32'd1, 32'd1, 35);
        bus.req_rd = 5'd20; bus.req_a = 32'd100; bus.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall result", bus.rsp_result, 32'd2);
            chk("stall rd", 32'(bus.rsp_rd), 32'd9);
            chk("stall req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        release_rsp("stall");
        chk("stall alu_a kept", bus.alu_a, 32'd1);

        // Reset asserted mid-WAIT.
        bus.req_funct3 = 3'b000; bus.req_funct7b5 = 1'b0; bus.req_is_imm = 1'b0;
        bus.req_rd = 5'd17; bus.req_a = 32'h0000_AAAA; bus.req_b = 32'd3; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("wait busy", 32'(bus.busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst wait req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst wait busy", 32'(bus.busy), 32'd0);
        chk("rst wait alu_a", bus.alu_a, 32'd0);
        chk("rst wait rsp_rd", 32'(bus.rsp_rd), 32'd0);
        chk("rst wait rsp_result", bus.rsp_result, 32'd0);
        chk("rst wait rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        issue("post rst add", 3'b000, 1'b0, 1'b0, 5'd21, 32'd40, 32'd2, 35);
        check_rsp("post rst add", 32'd42, 5'd21);
        release_rsp("post rst add");

`ifdef ALU_TIMEOUT_EN
        bus_t.req_funct3 = 3'b000; bus_t.req_rd = 5'd4;
        bus_t.req_a = 32'd5; bus_t.req_b = 32'd7; bus_t.req_valid = 1'b1;
        @(posedge clk); #1;
        bus_t.req_valid = 1'b0;
        edges = 0;
        while (!bus_t.rsp_valid && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("timeout latency", 32'(edges), 32'd17);
        chk("timeout err", 32'(bus_t.rsp_err), 32'd1);
        chk("timeout result", bus_t.rsp_result, 32'd0);
        chk("timeout rd", 32'(bus_t.rsp_rd), 32'd4);
        late_done = 1'b1;
        @(posedge clk); #1;
        late_done = 1'b0;
        chk("late done err", 32'(bus_t.rsp_err), 32'd1);
        chk("late done result", bus_t.rsp_result, 32'd0);
        chk("late done rsp_valid", 32'(bus_t.rsp_valid), 32'd1);
        bus_t.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus_t.rsp_ready = 1'b0;
        chk("timeout release", 32'(bus_t.req_ready), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
